downcounter_timer: RTL and testbench
====================================

// Module: downcounter_timer
// PURPOSE
//   Loadable WIDTH-bit down-counter timer. It is the counting-down counterpart of the team's
//   enable-gated up counter.
//   - Software/control logic loads a start value and gates countdown with enable.
//   - The block flags expiry with a one-cycle terminal-count pulse.
//   - It optionally auto-reloads the start value for periodic ticks.
//   - Used as a timeout/period generator beside the up counters in the control path.
// PARAMETERS
//   WIDTH   4   counter, load value and reload register width in bits
// PORTS
//   clk          input   1      rising-edge clock; the only clock
//   reset        input   1      asynchronous, active-high reset
//   load         input   1      capture load_val into count and reload register
//   load_val     input   WIDTH  start / reload value
//   enable       input   1      count-down gate; one decrement per enabled cycle
//   auto_reload  input   1      1 = periodic (reload on expiry), 0 = one-shot
//   count        output  WIDTH  current counter value (registered)
//   zero         output  1      combinational: count == 0
//   tc_pulse     output  1      registered; high for 1 cycle on expiry
//   busy         output  1      state != IDLE
//   paused       output  1      state == HOLD
// BEHAVIOUR
//   Reset (async, any time, incl. mid-run):
//     - count=0, reload_reg=0, tc_pulse=0, state=IDLE.
//     - So zero=1, busy=0, paused=0.
//   FSM states:
//     - IDLE: stopped, enable ignored, count holds.
//     - RUN:  counting.
//     - HOLD: counting suspended, count holds.
//   Priority each edge: reset > load > expiry/decrement > hold.
//   load=1 (any state):
//     - count<=load_val, reload_reg<=load_val, tc_pulse<=0.
//     - Next state: RUN if load_val!=0, else IDLE (no pulse).
//     - The load edge itself does not decrement, even if enable=1.
//   RUN, enable=1, count>1:
//     - count<=count-1, stay RUN.
//   RUN or HOLD, enable=1, count==1 (expiry):
//     - tc_pulse<=1.
//     - auto_reload=1: count<=reload_reg, state RUN.
//     - auto_reload=0: count<=0, state IDLE.
//   RUN, enable=0:
//     - Go to HOLD, count unchanged.
//   HOLD, enable=1:
//     - Go to RUN and decrement on the same edge (expiry rule applies if count==1).
//   tc_pulse is low on every edge except an expiry edge.
//     - With reload value 1 and auto_reload=1, tc_pulse stays high every enabled cycle;
//       count stays 1.
//   Latency: load -> count valid next cycle; from load, N enabled cycles -> tc_pulse
//     (N = load_val).
//   Width rules:
//     - Unsigned arithmetic.
//     - Decrement never wraps: count never goes 0 -> all-ones, since expiry stops at 1->0.
//     - Max load value 2^WIDTH-1.
//   auto_reload is sampled only on the expiry edge; changing it mid-run is legal.
//   load while busy restarts the count; a pending expiry on that edge is discarded.
// TESTING (WIDTH=4)
//   1. reset=1 with count mid-run (7) -> count=0, busy=0, tc_pulse=0 immediately
//      (asynchronous, before next clk edge).
//   2. One-shot: load 5, enable=1, auto_reload=0 -> count 5,4,3,2,1,0; tc_pulse high exactly
//      on the 1->0 edge; then IDLE, busy=0, count stays 0 with enable still 1.
//   3. Pause: load 6, enable 2 cycles (count 4), enable=0 3 cycles -> paused=1, count holds 4;
//      enable=1 -> 3,2,1,0 with a single tc_pulse.
//   4. Periodic: load 3, auto_reload=1, enable=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1,3;
//      tc_pulse on each 1->3 reload edge (3 pulses), busy=1 throughout.
//   5. Simultaneous: count=1, enable=1, load=1 with load_val=9 on same edge -> count=9,
//      tc_pulse=0, state RUN.
//   6. Edge values:
//      - load 0 -> IDLE, zero=1, no pulse.
//      - load 15 -> 15 enabled cycles to tc_pulse.
//      - load 1 + auto_reload -> tc_pulse every cycle.

Source files
------------

// File: rtl/downcounter_timer.sv
// Loadable down-counter timer with one-cycle terminal-count pulse and optional
// auto-reload, used as a timeout / period generator in the control path.
module downcounter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy,
    output logic             paused
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             step;
    logic             expire;

    // A step is an enabled cycle while running or held; expiry is the 1 -> 0 step.
    always_comb begin
        step   = (state == RUN || state == HOLD) && enable;
        expire = step && (count == ONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = (load_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = IDLE;
                RUN: begin
                    if (!enable) begin
                        state_next = HOLD;
                    end else if (expire && !auto_reload) begin
                        state_next = IDLE;
                    end
                end
                HOLD: begin
                    if (enable) begin
                        state_next = (expire && !auto_reload) ? IDLE : RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
            // A zero count can never be live; fall back to IDLE rather than wrap.
            if (state != IDLE && count == '0) begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        paused = (state == HOLD);
        zero   = (count == '0);
    end

    // Load wins over any pending expiry on the same edge and never decrements.
    always_comb begin
        count_next  = count;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
        end else if (expire) begin
            tc_next    = 1'b1;
            count_next = auto_reload ? reload_reg : '0;
        end else if (step && count > ONE) begin
            count_next = count - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
        end else begin
            count      <= count_next;
            reload_reg <= reload_next;
            tc_pulse   <= tc_next;
        end
    end

endmodule

// File: tb/tb_downcounter_timer.sv
// Self-checking bench for downcounter_timer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_downcounter_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       enable = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       zero;
    logic       tc_pulse;
    logic       busy;
    logic       paused;

    int tests = 0;
    int fails = 0;

    // Model state: remaining count, remembered start value, timer active, timer suspended.
    int m_count  = 0;
    int m_reload = 0;
    bit m_pulse  = 0;
    bit m_active = 0;
    bit m_hold   = 0;

    downcounter_timer #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .enable(enable),
        .auto_reload(auto_reload),
        .count(count),
        .zero(zero),
        .tc_pulse(tc_pulse),
        .busy(busy),
        .paused(paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count  <= 0;
            m_reload <= 0;
            m_pulse  <= 0;
            m_active <= 0;
            m_hold   <= 0;
        end else begin
            automatic int c   = m_count;
            automatic int r   = m_reload;
            automatic bit p   = 0;
            automatic bit act = m_active;
            automatic bit hld = m_hold;
            if (load) begin
                c   = int'(load_val);
                r   = int'(load_val);
                act = (load_val != 0);
                hld = 0;
            end else if (act && enable) begin
                hld = 0;
                if (c == 1) begin
                    p = 1;
                    if (auto_reload) begin
                        c = r;
                    end else begin
                        c   = 0;
                        act = 0;
                    end
                end else begin
                    c = c - 1;
                end
            end else if (act) begin
                hld = 1;
            end
            m_count  <= c;
            m_reload <= r;
            m_pulse  <= p;
            m_active <= act;
            m_hold   <= hld;
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("model.count", int'(count), m_count);
            checkOutput("model.zero", int'(zero), int'(m_count == 0));
            checkOutput("model.tc_pulse", int'(tc_pulse), int'(m_pulse));
            checkOutput("model.busy", int'(busy), int'(m_active));
            checkOutput("model.paused", int'(paused), int'(m_hold));
        end
    end

    task automatic applyStimulus(input logic l, input logic [3:0] lv, input logic en,
                                 input logic ar);
        @(negedge clk);
        load        = l;
        load_val    = lv;
        enable      = en;
        auto_reload = ar;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #20 reset = 1'b0;

        // Asynchronous reset while counting at 7.
        applyStimulus(1, 4'd9, 1, 0); tick();
        applyStimulus(0, 4'd9, 1, 0); tick(); tick();
        checkOutput("pre_reset.count", int'(count), 7);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset.count", int'(count), 0);
        checkOutput("async_reset.busy", int'(busy), 0);
        checkOutput("async_reset.tc", int'(tc_pulse), 0);
        checkOutput("async_reset.zero", int'(zero), 1);
        @(negedge clk);
        reset = 1'b0;

        // One-shot from 5.
        applyStimulus(1, 4'd5, 1, 0); tick();
        checkOutput("oneshot.load", int'(count), 5);
        applyStimulus(0, 4'd0, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            tick();
            checkOutput("oneshot.count", int'(count), i);
            checkOutput("oneshot.tc_low", int'(tc_pulse), 0);
        end
        tick();
        checkOutput("oneshot.final", int'(count), 0);
        checkOutput("oneshot.tc", int'(tc_pulse), 1);
        checkOutput("oneshot.busy", int'(busy), 0);
        tick();
        checkOutput("oneshot.idle_count", int'(count), 0);
        checkOutput("oneshot.idle_tc", int'(tc_pulse), 0);

        // Pause and resume.
        applyStimulus(1, 4'd6, 1, 0); tick();
        applyStimulus(0, 4'd0, 1, 0); tick(); tick();
        checkOutput("pause.count4", int'(count), 4);
        applyStimulus(0, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pause.hold", int'(count), 4);
            checkOutput("pause.paused", int'(paused), 1);
        end
        applyStimulus(0, 4'd0, 1, 0);
        for (int i = 3; i >= 1; i--) begin
            tick();
            checkOutput("pause.resume", int'(count), i);
        end
        tick();
        checkOutput("pause.end_count", int'(count), 0);
        checkOutput("pause.end_tc", int'(tc_pulse), 1);

        // Periodic reload of 3.
        applyStimulus(1, 4'd3, 1, 1); tick();
        applyStimulus(0, 4'd0, 1, 1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            checkOutput("periodic.count", int'(count), (i % 3 == 0) ? 3 : 3 - (i % 3));
            checkOutput("periodic.tc", int'(tc_pulse), int'(i % 3 == 0));
            checkOutput("periodic.busy", int'(busy), 1);
        end

        // Load coinciding with a pending expiry.
        applyStimulus(1, 4'd1, 1, 0); tick();
        applyStimulus(1, 4'd9, 1, 0); tick();
        checkOutput("simul.count", int'(count), 9);
        checkOutput("simul.tc", int'(tc_pulse), 0);
        checkOutput("simul.busy", int'(busy), 1);
        checkOutput("simul.paused", int'(paused), 0);

        // Edge values: 0, 15, 1 with auto-reload.
        applyStimulus(1, 4'd0, 1, 0); tick();
        checkOutput("load0.zero", int'(zero), 1);
        checkOutput("load0.busy", int'(busy), 0);
        checkOutput("load0.tc", int'(tc_pulse), 0);
        applyStimulus(1, 4'd15, 1, 0); tick();
        applyStimulus(0, 4'd0, 1, 0);
        for (int i = 1; i < 15; i++) tick();
        checkOutput("load15.before", int'(tc_pulse), 0);
        checkOutput("load15.count1", int'(count), 1);
        tick();
        checkOutput("load15.tc", int'(tc_pulse), 1);
        applyStimulus(1, 4'd1, 1, 1); tick();
        applyStimulus(0, 4'd0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reload1.tc", int'(tc_pulse), 1);
            checkOutput("reload1.count", int'(count), 1);
        end

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus(logic'($urandom_range(0, 9) == 0),
                              4'($urandom_range(0, 15)),
                              logic'($urandom_range(0, 3) != 0),
                              logic'($urandom_range(0, 1)));
                tick();
            end
        end

        applyStimulus(0, 4'd0, 0, 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
